if_fetch_queue: RTL
===================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the queue entry count; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high (1'b1 = RstEnable).
REQ-005 The block SHALL have port rom_ce  output  1  instruction ROM chip enable (1 = ChipEnable).
REQ-006 The block SHALL have port rom_addr  output  32  instruction ROM byte address; bits [1:0] always 0.
REQ-007 The block SHALL have port rom_inst  input  32  ROM read data, combinationally valid in the same cycle as rom_ce/rom_addr.
REQ-008 The block SHALL have port flush  input  1  redirect request from branch/exception logic.
REQ-009 The block SHALL have port flush_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-010 The block SHALL have port out_valid  output  1  the head entry is valid for decode.
REQ-011 The block SHALL have port out_ready  input  1  decode (IF/ID) accepts the head entry this cycle.
REQ-012 The block SHALL have port out_inst  output  32  instruction word of the head entry.
REQ-013 The block SHALL have port out_pc  output  32  byte address of the head entry.

Function
REQ-014 State: fetch_pc register, circular buffer of DEPTH {pc, inst} entries, rd_ptr/wr_ptr (log2 DEPTH bits, wrap mod DEPTH), count (0..DEPTH), FSM state {IDLE, RUN}.
REQ-015 FSM: IDLE for exactly one cycle after rst deasserts, then RUN; in IDLE rom_ce = 0 and no fetch occurs; RUN persists until rst.
REQ-016 rom_addr SHALL equal fetch_pc in every cycle.
REQ-017 rom_ce SHALL be 1 iff state = RUN, rst = 0, flush = 0, and count < DEPTH; rom_ce is never asserted when full, even if a pop occurs in the same cycle.
REQ-018 Push: in a cycle with rom_ce = 1, at the clock edge {fetch_pc, rom_inst} is written at wr_ptr, wr_ptr increments, and fetch_pc increments by 4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 Pop: when out_valid = 1 and out_ready = 1, at the clock edge rd_ptr increments.
REQ-020 count SHALL increment on push only, decrement on pop only, and be unchanged on simultaneous push and pop.
REQ-021 out_valid SHALL be (count != 0); out_inst/out_pc SHALL show the entry at rd_ptr when out_valid = 1, and 32'h0 when count = 0.
REQ-022 Fetch-to-output latency SHALL be 1 cycle: an instruction fetched in cycle N appears with out_valid = 1 in cycle N+1 if the queue was empty.
REQ-023 Flush has priority over push and pop: at the edge where flush = 1, count, rd_ptr and wr_ptr clear to 0, fetch_pc loads {flush_pc[31:2], 2'b00}, and no entry is written or consumed (out_ready in that cycle is ignored).
REQ-024 After a flush, the first fetch from the new target occurs in the next cycle (if flush is low then), and out_valid rises one cycle later.
REQ-025 Back-to-back flush cycles SHALL each reload fetch_pc; the last one wins.
REQ-026 In steady state with out_ready held at 1, throughput SHALL be one instruction per cycle with sequential out_pc.
REQ-027 Order SHALL be preserved: instructions leave in fetch order; no entry is dropped or duplicated except those discarded by flush.

Reset
REQ-028 While rst = 1 at a clock edge, fetch_pc <= RESET_PC, pointers and count <= 0, and state <= IDLE.
REQ-029 While rst = 1 (combinationally), rom_ce = 0, out_valid = 0, and out_inst = out_pc = 32'h0; rst mid-operation discards all queued entries.
REQ-030 rst overrides flush when both are asserted.

Verification
REQ-031 Reset release with out_ready = 1 and ROM word k = k+1 -> cycle 1 after release: rom_ce = 1, rom_addr = 0; next cycle: out_valid = 1, out_pc = 0, out_inst = 1; then out_pc = 4, 8, 12, ... every cycle.
REQ-032 out_ready = 0 from reset -> exactly 4 fetches (0x0..0xC), then rom_ce = 0 and count = 4; raise out_ready -> pops 0x0 first and fetching resumes with 0x10 after the first pop.
REQ-033 flush = 1 with flush_pc = 32'h0000_0103 while 3 entries are queued -> next cycle: out_valid = 0, rom_addr = 32'h0000_0100; one cycle later out_pc = 32'h100.
REQ-034 flush with out_ready = 1 and a full queue in the same cycle -> no pop is counted, the queue is empty, and old entries never appear on out_pc.
REQ-035 RESET_PC = 32'hFFFF_FFF8, out_ready = 1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-036 rst = 1 for one cycle mid-stream with 2 entries queued -> out_valid = 0 and rom_ce = 0 immediately; one IDLE cycle follows, then fetching restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: sequential PC generator feeding a DEPTH-entry
// {pc, inst} queue toward decode, with flush redirect and one idle cycle after reset.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   START_PC   = {RESET_PC[31:2], 2'b00};

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic push;
  logic pop;
  logic unused_flush_bits;

  assign unused_flush_bits = ^flush_pc[1:0];

  // A full queue never fetches, even when decode drains an entry this cycle.
  assign push      = (state == RUN) && !rst && !flush && (count < FULL_COUNT);
  assign out_valid = !rst && (count != '0);
  assign pop       = out_valid && out_ready && !flush;

  assign rom_ce    = push;
  assign rom_addr  = fetch_pc;
  assign out_pc    = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_inst  = out_valid ? mem_inst[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= START_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase

      // Flush discards everything queued and wins over any push or pop.
      if (flush) begin
        fetch_pc <= {flush_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_inst[wr_ptr] <= rom_inst;
    end
  end

endmodule
